// File: rtl/color_mix_pkg.sv
// Shared types and constants for the colour-mix video pipeline:
// tint modes, luma coefficients and brightness-ramp states.
package color_mix_pkg;

    typedef enum logic [2:0] {
        MODE_PASS  = 3'd0,
        MODE_GREEN = 3'd1,
        MODE_AMBER = 3'd2,
        MODE_CYAN  = 3'd3,
        MODE_GRAY  = 3'd4,
        MODE_SEPIA = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        BR_STEADY  = 2'd0,
        BR_RAMP_UP = 2'd1,
        BR_RAMP_DN = 2'd2
    } bright_state_e;

    // Luma weights in 1/256 units; they sum to 255 so the weighted sum never overflows.
    localparam logic [7:0]  LUMA_CR   = 8'd54;
    localparam logic [7:0]  LUMA_CG   = 8'd183;
    localparam logic [7:0]  LUMA_CB   = 8'd18;
    localparam int unsigned LUMA_FRAC = 8;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } vid_timing_t;

endpackage

// File: rtl/color_luma.sv
// First pipeline stage of color_mix_pipe: registered luma of an RGB pixel,
// advancing only on the pixel enable.
module color_luma
    import color_mix_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ce,
    input  logic [DW-1:0] i_r,
    input  logic [DW-1:0] i_g,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_luma
);

    localparam int unsigned SW = DW + 8;

    logic [SW-1:0] w_sum;
    logic [DW-1:0] r_luma;

    assign w_sum = (SW'(i_r) * SW'(LUMA_CR))
                 + (SW'(i_g) * SW'(LUMA_CG))
                 + (SW'(i_b) * SW'(LUMA_CB));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_luma <= '0;
        end else if (i_ce) begin
            r_luma <= DW'(w_sum >> LUMA_FRAC);
        end
    end

    assign o_luma = r_luma;

endmodule

// File: rtl/color_mix_pipe.sv
// Three-stage colour-mix pipeline (luma, tint, brightness) with frame-synchronous
// mode/brightness updates. Define COLOR_MIX_PIPE_FADE_EN to enable the brightness stage and ramp.
module color_mix_pipe
    import color_mix_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned LVL_W = 4
) (
    input  logic             clk_vid,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [2:0]       mono,
    input  logic [LVL_W-1:0] bright,
    input  logic [DW-1:0]    R_in,
    input  logic [DW-1:0]    G_in,
    input  logic [DW-1:0]    B_in,
    input  logic             HSync_in,
    input  logic             VSync_in,
    input  logic             HBlank_in,
    input  logic             VBlank_in,
    output logic [DW-1:0]    R_out,
    output logic [DW-1:0]    G_out,
    output logic [DW-1:0]    B_out,
    output logic             HSync_out,
    output logic             VSync_out,
    output logic             HBlank_out,
    output logic             VBlank_out,
    output logic [2:0]       mode_act,
    output logic [LVL_W-1:0] level_act
);

    localparam logic [LVL_W-1:0] LVL_FULL = '1;

    // ---------------- frame edge detection ----------------
    logic r_vs_prev;
    logic r_vs_armed;
    logic w_frame_edge;

    // Armed only after VSync has been seen low, so a reset released mid-pulse cannot fake an edge.
    assign w_frame_edge = ce_pix & VSync_in & ~r_vs_prev & r_vs_armed;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_prev  <= 1'b0;
            r_vs_armed <= 1'b0;
        end else if (ce_pix) begin
            r_vs_prev <= VSync_in;
            if (!VSync_in) begin
                r_vs_armed <= 1'b1;
            end
        end
    end

    // ---------------- active mode ----------------
    logic [2:0] r_mode_act;
    logic [2:0] w_mode_nxt;

    assign w_mode_nxt = w_frame_edge ? mono : r_mode_act;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_act <= '0;
        end else if (ce_pix) begin
            r_mode_act <= w_mode_nxt;
        end
    end

    assign mode_act = r_mode_act;

    // ---------------- brightness level ----------------
`ifdef COLOR_MIX_PIPE_FADE_EN
    bright_state_e    w_bstate;
    logic [LVL_W-1:0] r_level_act;
    logic [LVL_W-1:0] w_level_nxt;

    always_comb begin
        w_bstate = BR_STEADY;
        if (r_level_act < bright) begin
            w_bstate = BR_RAMP_UP;
        end else if (r_level_act > bright) begin
            w_bstate = BR_RAMP_DN;
        end
    end

    // One step per frame edge; stepping only toward bright keeps the level inside [0, full].
    always_comb begin
        w_level_nxt = r_level_act;
        if (w_frame_edge) begin
            case (w_bstate)
                BR_RAMP_UP: w_level_nxt = r_level_act + LVL_W'(1);
                BR_RAMP_DN: w_level_nxt = r_level_act - LVL_W'(1);
                default:    w_level_nxt = r_level_act;
            endcase
        end
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_level_act <= LVL_FULL;
        end else if (ce_pix) begin
            r_level_act <= w_level_nxt;
        end
    end

    assign level_act = r_level_act;
`else
    logic w_unused_bright;

    assign w_unused_bright = ^bright;
    assign level_act       = LVL_FULL;
`endif

    // ---------------- S1: luma, pixel and controls delayed alongside ----------------
    vid_timing_t   w_tim_in;
    vid_timing_t   r_s1_tim;
    logic [DW-1:0] r_s1_r;
    logic [DW-1:0] r_s1_g;
    logic [DW-1:0] r_s1_b;
    logic [DW-1:0] w_s1_luma;
    logic [2:0]    r_s1_mode;
`ifdef COLOR_MIX_PIPE_FADE_EN
    logic [LVL_W-1:0] r_s1_lvl;
    logic [LVL_W-1:0] r_s2_lvl;
`endif

    assign w_tim_in = {HSync_in, VSync_in, HBlank_in, VBlank_in};

    color_luma #(
        .DW(DW)
    ) u_luma (
        .i_clk   (clk_vid),
        .i_rst_n (reset_n),
        .i_ce    (ce_pix),
        .i_r     (R_in),
        .i_g     (G_in),
        .i_b     (B_in),
        .o_luma  (w_s1_luma)
    );

    // Mode/level travel with the pixel so an edge's new values hit the pixel sampled on that edge.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_r    <= '0;
            r_s1_g    <= '0;
            r_s1_b    <= '0;
            r_s1_tim  <= '0;
            r_s1_mode <= '0;
`ifdef COLOR_MIX_PIPE_FADE_EN
            r_s1_lvl  <= '0;
`endif
        end else if (ce_pix) begin
            r_s1_r    <= R_in;
            r_s1_g    <= G_in;
            r_s1_b    <= B_in;
            r_s1_tim  <= w_tim_in;
            r_s1_mode <= w_mode_nxt;
`ifdef COLOR_MIX_PIPE_FADE_EN
            r_s1_lvl  <= w_level_nxt;
`endif
        end
    end

    // ---------------- S2: tint ----------------
    logic [DW-1:0] w_s2_r;
    logic [DW-1:0] w_s2_g;
    logic [DW-1:0] w_s2_b;
    logic [DW-1:0] r_s2_r;
    logic [DW-1:0] r_s2_g;
    logic [DW-1:0] r_s2_b;
    vid_timing_t   r_s2_tim;

    always_comb begin
        w_s2_r = w_s1_luma;
        w_s2_g = w_s1_luma;
        w_s2_b = w_s1_luma;
        case (mode_e'(r_s1_mode))
            MODE_PASS: begin
                w_s2_r = r_s1_r;
                w_s2_g = r_s1_g;
                w_s2_b = r_s1_b;
            end
            MODE_GREEN: begin
                w_s2_r = '0;
                w_s2_b = '0;
            end
            MODE_AMBER: begin
                w_s2_g = w_s1_luma - (w_s1_luma >> 2);
                w_s2_b = '0;
            end
            MODE_CYAN: begin
                w_s2_r = '0;
            end
            MODE_SEPIA: begin
                w_s2_g = w_s1_luma - (w_s1_luma >> 3);
                w_s2_b = w_s1_luma - (w_s1_luma >> 1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_r   <= '0;
            r_s2_g   <= '0;
            r_s2_b   <= '0;
            r_s2_tim <= '0;
`ifdef COLOR_MIX_PIPE_FADE_EN
            r_s2_lvl <= '0;
`endif
        end else if (ce_pix) begin
            r_s2_r   <= w_s2_r;
            r_s2_g   <= w_s2_g;
            r_s2_b   <= w_s2_b;
            r_s2_tim <= r_s1_tim;
`ifdef COLOR_MIX_PIPE_FADE_EN
            r_s2_lvl <= r_s1_lvl;
`endif
        end
    end

    // ---------------- S3: brightness ----------------
    logic [DW-1:0] w_s3_r;
    logic [DW-1:0] w_s3_g;
    logic [DW-1:0] w_s3_b;
    logic [DW-1:0] r_s3_r;
    logic [DW-1:0] r_s3_g;
    logic [DW-1:0] r_s3_b;
    vid_timing_t   r_s3_tim;

`ifdef COLOR_MIX_PIPE_FADE_EN
    localparam int unsigned PW = DW + LVL_W;

    // Scale factor is level+1 over 2^LVL_W, so full scale returns c unchanged.
    function automatic logic [DW-1:0] f_scale(input logic [DW-1:0] c, input logic [LVL_W-1:0] lvl);
        logic [PW-1:0] prod;
        prod = PW'(c) * (PW'(lvl) + PW'(1));
        return DW'(prod >> LVL_W);
    endfunction

    assign w_s3_r = f_scale(r_s2_r, r_s2_lvl);
    assign w_s3_g = f_scale(r_s2_g, r_s2_lvl);
    assign w_s3_b = f_scale(r_s2_b, r_s2_lvl);
`else
    assign w_s3_r = r_s2_r;
    assign w_s3_g = r_s2_g;
    assign w_s3_b = r_s2_b;
`endif

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_s3_r   <= '0;
            r_s3_g   <= '0;
            r_s3_b   <= '0;
            r_s3_tim <= '0;
        end else if (ce_pix) begin
            r_s3_r   <= w_s3_r;
            r_s3_g   <= w_s3_g;
            r_s3_b   <= w_s3_b;
            r_s3_tim <= r_s2_tim;
        end
    end

    assign R_out      = r_s3_r;
    assign G_out      = r_s3_g;
    assign B_out      = r_s3_b;
    assign HSync_out  = r_s3_tim.hsync;
    assign VSync_out  = r_s3_tim.vsync;
    assign HBlank_out = r_s3_tim.hblank;
    assign VBlank_out = r_s3_tim.vblank;

endmodule

// File: tb/tb_color_mix_pipe.sv
// Self-checking bench for color_mix_pipe: behavioural model compared every cycle,
// plus literal expectations; follows COLOR_MIX_PIPE_FADE_EN like the design.
module tb_color_mix_pipe;

    localparam int unsigned DW    = 8;
    localparam int unsigned LVL_W = 4;
    localparam int          FULL  = 15;
`ifdef COLOR_MIX_PIPE_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic             clk_vid = 1'b0;
    logic             reset_n = 1'b0;
    logic             ce_pix  = 1'b0;
    logic [2:0]       mono    = '0;
    logic [LVL_W-1:0] bright  = 4'd15;
    logic [DW-1:0]    R_in = '0, G_in = '0, B_in = '0;
    logic             HSync_in = 1'b0, VSync_in = 1'b0, HBlank_in = 1'b0, VBlank_in = 1'b0;
    logic [DW-1:0]    R_out, G_out, B_out;
    logic             HSync_out, VSync_out, HBlank_out, VBlank_out;
    logic [2:0]       mode_act;
    logic [LVL_W-1:0] level_act;

    always #5 clk_vid = ~clk_vid;

    color_mix_pipe #(
        .DW    (DW),
        .LVL_W (LVL_W)
    ) dut (
        .clk_vid    (clk_vid),
        .reset_n    (reset_n),
        .ce_pix     (ce_pix),
        .mono       (mono),
        .bright     (bright),
        .R_in       (R_in),
        .G_in       (G_in),
        .B_in       (B_in),
        .HSync_in   (HSync_in),
        .VSync_in   (VSync_in),
        .HBlank_in  (HBlank_in),
        .VBlank_in  (VBlank_in),
        .R_out      (R_out),
        .G_out      (G_out),
        .B_out      (B_out),
        .HSync_out  (HSync_out),
        .VSync_out  (VSync_out),
        .HBlank_out (HBlank_out),
        .VBlank_out (VBlank_out),
        .mode_act   (mode_act),
        .level_act  (level_act)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
    } px_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  cmp_on = 1'b0;

    px_t mq[$];
    px_t exp_px;
    int  m_mode;
    int  m_lvl;
    bit  m_vs_prev;
    bit  m_seen_low;

    int brt[12] = '{12, 12, 12, 12, 0, 0, 14, 14, 14, 15, 15, 15};
    int lvx[12] = '{14, 13, 12, 12, 11, 10, 11, 12, 13, 14, 15, 15};

    logic [7:0]  sr[24], sg[24], sb[24];
    logic [27:0] rec_a[27], rec_b[27];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    function automatic logic [63:0] dut_px();
        return 64'({R_out, G_out, B_out, HSync_out, VSync_out, HBlank_out, VBlank_out});
    endfunction

    // What the pixel must look like at the output, straight from the colour rules.
    function automatic px_t expect_px(input int r, input int g, input int b, input int mode,
                                      input int lvl, input logic hs, input logic vs,
                                      input logic hb, input logic vb);
        int  y;
        int  c[3];
        px_t p;
        y = (r * 54 + g * 183 + b * 18) / 256;
        case (mode)
            0:       c = '{r, g, b};
            1:       c = '{0, y, 0};
            2:       c = '{y, y - y / 4, 0};
            3:       c = '{0, y, y};
            5:       c = '{y, y - y / 8, y - y / 2};
            default: c = '{y, y, y};
        endcase
        if (FADE) begin
            for (int i = 0; i < 3; i++) c[i] = c[i] * (lvl + 1) / (1 << LVL_W);
        end
        p.r  = 8'(c[0]);
        p.g  = 8'(c[1]);
        p.b  = 8'(c[2]);
        p.hs = hs;
        p.vs = vs;
        p.hb = hb;
        p.vb = vb;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        mq.push_back('0);
        mq.push_back('0);
        exp_px     = '0;
        m_mode     = 0;
        m_lvl      = FULL;
        m_vs_prev  = 1'b0;
        m_seen_low = 1'b0;
    endtask

    always @(posedge clk_vid or negedge reset_n) begin : mdl
        bit fe;
        if (!reset_n) begin
            model_reset();
        end else if (ce_pix) begin
            fe = VSync_in && !m_vs_prev && m_seen_low;
            if (!VSync_in) m_seen_low = 1'b1;
            m_vs_prev = VSync_in;
            if (fe) begin
                m_mode = int'(mono);
                if (FADE) begin
                    if (m_lvl < int'(bright)) m_lvl++;
                    else if (m_lvl > int'(bright)) m_lvl--;
                end
            end
            mq.push_back(expect_px(int'(R_in), int'(G_in), int'(B_in), m_mode, m_lvl,
                                   HSync_in, VSync_in, HBlank_in, VBlank_in));
            exp_px = mq.pop_front();
        end
    end

    always @(negedge clk_vid) begin
        if (cmp_on) begin
            check("model_pixel", dut_px(), 64'(exp_px));
            check("model_mode", 64'(mode_act), 64'(m_mode));
            check("model_level", 64'(level_act), 64'(m_lvl));
        end
    end

    task automatic drive(input logic ce, input int r, input int g, input int b,
                         input logic hs, input logic vs, input logic hb, input logic vb);
        ce_pix    = ce;
        R_in      = 8'(r);
        G_in      = 8'(g);
        B_in      = 8'(b);
        HSync_in  = hs;
        VSync_in  = vs;
        HBlank_in = hb;
        VBlank_in = vb;
        @(posedge clk_vid);
        #1;
    endtask

    task automatic pix(input int r, input int g, input int b, input logic vs);
        drive(1'b1, r, g, b, 1'b0, vs, 1'b0, vs);
    endtask

    task automatic frame(input int r, input int g, input int b);
        pix(r, g, b, 1'b0);
        pix(r, g, b, 1'b1);
    endtask

    task automatic run_seq(input bit gaps);
        ce_pix  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk_vid);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 27; k++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 3)) begin
                    mono   = 3'($urandom);
                    bright = 4'($urandom);
                    drive(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
                end
            end
            bright = 4'd9;
            mono   = (k < 12) ? 3'd2 : 3'd5;
            if (k < 24) begin
                drive(1'b1, int'(sr[k]), int'(sg[k]), int'(sb[k]), (k % 4) == 0,
                      (k % 8) >= 6, 1'b0, (k % 8) >= 6);
            end else begin
                drive(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            if (gaps) rec_b[k] = 28'(dut_px());
            else      rec_a[k] = 28'(dut_px());
        end
    endtask

    initial begin
        for (int k = 0; k < 24; k++) begin
            sr[k] = 8'($urandom);
            sg[k] = 8'($urandom);
            sb[k] = 8'($urandom);
        end
        model_reset();
        repeat (3) @(posedge clk_vid);
        #1;
        cmp_on = 1'b1;
        check("reset_pixel", dut_px(), 64'(0));
        check("reset_mode", 64'(mode_act), 64'(0));
        check("reset_level", 64'(level_act), 64'(15));
        reset_n = 1'b1;

        // Pass-through latency and timing alignment.
        drive(1'b1, 'h12, 'h34, 'h56, 1'b1, 1'b0, 1'b0, 1'b0);
        pix(0, 0, 0, 1'b0);
        check("latency_not_early", 64'(HSync_out), 64'(0));
        pix(0, 0, 0, 1'b0);
        check("latency_pixel", 64'({R_out, G_out, B_out}), 64'h123456);
        check("latency_hsync", 64'(HSync_out), 64'(1));
        pix(0, 0, 0, 1'b0);
        check("hsync_width", 64'(HSync_out), 64'(0));

        // Mode change mid-frame waits for the next VSync rise.
        mono = 3'd1;
        repeat (3) pix(9, 9, 9, 1'b0);
        check("mode_held_midframe", 64'(mode_act), 64'(0));
        pix('h40, 'h80, 'hC0, 1'b1);
        check("mode_on_edge", 64'(mode_act), 64'(1));
        pix(0, 0, 0, 1'b1);
        pix(0, 0, 0, 1'b1);
        check("green_pixel", 64'({R_out, G_out, B_out}), 64'h007600);

        mono = 3'd2;
        frame(255, 255, 255);
        check("amber_mode", 64'(mode_act), 64'(2));
        pix(0, 0, 0, 1'b1);
        pix(0, 0, 0, 1'b1);
        check("amber_white", 64'({R_out, G_out, B_out}), 64'hFEBF00);

        for (int m = 3; m < 8; m++) begin
            mono = 3'(m);
            frame('h90, 'h30, 'hE0);
            pix(1, 2, 3, 1'b1);
            pix(4, 5, 6, 1'b1);
            if (m == 5) check("sepia_pixel", 64'({R_out, G_out, B_out}), 64'h504628);
            if (m == 7) check("gray7_pixel", 64'({R_out, G_out, B_out}), 64'h505050);
        end

        // Brightness ramp: down, redirected up, saturating at bright.
        mono = 3'd0;
        for (int i = 0; i < 12; i++) begin
            bright = 4'(brt[i]);
            frame(255, 255, 255);
            check("level_ramp", 64'(level_act), 64'(FADE ? lvx[i] : FULL));
            if (i == 3) begin
                pix(0, 0, 0, 1'b1);
                pix(0, 0, 0, 1'b1);
                check("fade_pixel", 64'({R_out, G_out, B_out}), FADE ? 64'hCFCFCF : 64'hFFFFFF);
            end
        end
        bright = 4'd0;
        repeat (17) frame(200, 100, 50);
        check("level_floor", 64'(level_act), 64'(FADE ? 0 : FULL));
        bright = 4'd15;
        mono   = 3'd3;
        frame(255, 255, 255);
        frame(255, 255, 255);
        check("level_rising", 64'(level_act), 64'(FADE ? 2 : FULL));

        // Asynchronous reset mid-ramp, released while VSync is high.
        @(posedge clk_vid);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_pixel", dut_px(), 64'(0));
        check("async_reset_mode", 64'(mode_act), 64'(0));
        check("async_reset_level", 64'(level_act), 64'(15));
        @(posedge clk_vid);
        #1;
        reset_n = 1'b1;
        bright  = 4'd0;
        repeat (4) pix(77, 88, 99, 1'b1);
        check("no_edge_after_reset_mode", 64'(mode_act), 64'(0));
        check("no_edge_after_reset_level", 64'(level_act), 64'(15));
        frame(10, 20, 30);
        check("fresh_edge_mode", 64'(mode_act), 64'(3));
        check("fresh_edge_level", 64'(level_act), 64'(FADE ? 14 : FULL));

        // Sparse pixel enable must only stretch the output stream in time.
        run_seq(1'b0);
        run_seq(1'b1);
        for (int k = 0; k < 27; k++) begin
            check("sparse_ce_stream", 64'(rec_b[k]), 64'(rec_a[k]));
        end

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
